// File: rtl/jtdd_dwnld_router_if.sv
// Bundles the ioctl download port with the SDRAM and PROM programming ports.
// The slave modport is the router side; the master modport is the frame/test side.
interface jtdd_dwnld_router_if #(
   parameter int unsigned PW = 2
);
   logic          downloading;
   logic [25:0]   ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic          ioctl_wr;
   logic [21:0]   prog_addr;
   logic [7:0]    prog_data;
   logic [1:0]    prog_mask;
   logic          prog_we;
   logic          sdram_ack;
   logic [PW-1:0] prom_we;
   logic [7:0]    prom_addr;
   logic [7:0]    prom_data;
   logic          fifo_full;
   logic          ovf;
   logic          dwn_done;

   modport slave (
      input  downloading, ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
      output prog_addr, prog_data, prog_mask, prog_we,
      output prom_we, prom_addr, prom_data, fifo_full, ovf, dwn_done
   );

   modport master (
      output downloading, ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
      input  prog_addr, prog_data, prog_mask, prog_we,
      input  prom_we, prom_addr, prom_data, fifo_full, ovf, dwn_done
   );
endinterface

// File: rtl/jtdd_dwnld_router.sv
// Decodes ioctl download bytes into buffered SDRAM writes or direct PROM strobes.
// SDRAM writes queue in a small FIFO so bursts survive a slow sdram_ack.
module jtdd_dwnld_router #(
   parameter int unsigned PW          = 2,
   parameter int unsigned FIFOAW      = 2,
   parameter logic [21:0] ADPCM_START = 22'h30000,
   parameter logic [21:0] CHAR_START  = 22'h50000,
   parameter logic [21:0] SCR_START   = 22'h60000,
   parameter logic [21:0] OBJ_START   = 22'hA0000,
   parameter logic [21:0] MCU_START   = 22'h120000,
   parameter logic [21:0] PROM_START  = 22'h124000,
   parameter logic [21:0] SCR_OFFSET  = 22'h60000,
   parameter logic [21:0] OBJ_OFFSET  = 22'h80000,
   parameter logic [21:0] MCU_OFFSET  = 22'h180000
)(
   input logic              clk,
   input logic              rst_n,
   jtdd_dwnld_router_if.slave bus
);
   localparam int unsigned DEPTH = 2**FIFOAW;
   // Half of each interleaved region, in 64kB units
   localparam logic [5:0]  SCR_H = 6'((OBJ_START - SCR_START) >> 17);
   localparam logic [5:0]  OBJ_H = 6'((MCU_START - OBJ_START) >> 17);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   typedef struct packed {
      logic [21:0] addr;
      logic [1:0]  mask;
      logic [7:0]  data;
   } wr_t;

   // Returns {top_half, sdram_addr} for the half-interleaved SCR/OBJ layout
   function automatic logic [22:0] f_half(input logic [21:0] a, input logic [5:0] base,
                                          input logic [5:0] half, input logic [21:0] offs);
      logic [5:0] idx;
      logic       top;
      idx = a[21:16] - base;
      top = (idx >= half);
      if (top) idx = idx - half;
      return {top, offs + {idx, a[15:6], a[3:0], a[5:4]}};
   endfunction

   state_t              r_state, w_nxt;
   wr_t                 r_mem [DEPTH];
   wr_t                 r_prog;
   wr_t                 w_dec;
   logic [FIFOAW-1:0]   r_wp, r_rp;
   logic [FIFOAW:0]     r_cnt;
   logic [PW-1:0]       r_prom_we, w_strb;
   logic [7:0]          r_prom_addr, r_prom_data;
   logic                r_dl_d, r_ovf, r_pend;
   logic [21:0]         w_a;
   logic [1:0]          w_m8;
   logic [22:0]         w_half;
   logic [17:0]         w_k;
   logic                w_sd, w_wr, w_sd_wr, w_prom_wr;
   logic                w_empty, w_full, w_pop, w_push, w_drop;
   logic                w_rise, w_fall, w_armed, w_done;

   assign w_a     = bus.ioctl_addr[21:0];
   assign w_m8    = {~w_a[0], w_a[0]};
   assign w_k     = 18'((bus.ioctl_addr - 26'(PROM_START)) >> 8);
   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == (FIFOAW+1)'(DEPTH));

   always_comb begin
      w_dec      = '0;
      w_dec.data = bus.ioctl_dout;
      w_sd       = 1'b1;
      w_half     = '0;
      if (bus.ioctl_addr < 26'(ADPCM_START) || bus.ioctl_addr < 26'(CHAR_START)) begin
         w_dec.addr = {1'b0, w_a[21:1]};
         w_dec.mask = w_m8;
      end else if (bus.ioctl_addr < 26'(SCR_START)) begin
         w_dec.addr = {1'b0, w_a[21:5], w_a[2:0], w_a[4]};
         w_dec.mask = {~w_a[3], w_a[3]};
      end else if (bus.ioctl_addr < 26'(OBJ_START)) begin
         w_half     = f_half(w_a, SCR_START[21:16], SCR_H, SCR_OFFSET);
         w_dec.addr = w_half[21:0];
         w_dec.mask = w_half[22] ? 2'b01 : 2'b10;
      end else if (bus.ioctl_addr < 26'(MCU_START)) begin
         w_half     = f_half(w_a, OBJ_START[21:16], OBJ_H, OBJ_OFFSET);
         w_dec.addr = w_half[21:0];
         w_dec.mask = w_half[22] ? 2'b01 : 2'b10;
      end else if (bus.ioctl_addr < 26'(PROM_START)) begin
         w_dec.addr = MCU_OFFSET + {9'd0, w_a[13:1]};
         w_dec.mask = w_m8;
      end else begin
         w_sd = 1'b0;
      end
   end

   // Out-of-range PROM index matches no strobe, so the byte is silently discarded
   always_comb begin
      w_strb = '0;
      for (int unsigned k = 0; k < PW; k++) w_strb[k] = (w_k == 18'(k));
   end

   assign w_wr      = bus.ioctl_wr & bus.downloading;
   assign w_sd_wr   = w_wr & w_sd;
   assign w_prom_wr = w_wr & ~w_sd;
   assign w_push    = w_sd_wr & (~w_full | w_pop);
   assign w_drop    = w_sd_wr & w_full & ~w_pop;

   // Loading prog_* takes the head out of the FIFO, so REQ holds one entry beyond the FIFO depth
   always_comb begin
      w_nxt = r_state;
      w_pop = 1'b0;
      unique case (r_state)
         S_IDLE: if (!w_empty) begin
            w_pop = 1'b1;
            w_nxt = S_REQ;
         end
         S_REQ: if (bus.sdram_ack) begin
            if (!w_empty) w_pop = 1'b1;
            else          w_nxt = S_IDLE;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   assign w_rise  = bus.downloading & ~r_dl_d;
   assign w_fall  = ~bus.downloading & r_dl_d;
   assign w_armed = r_pend | w_fall;
   assign w_done  = w_armed & ~bus.downloading & w_empty & (r_state == S_IDLE);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= w_dec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_prog  <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_pop)  r_prog <= r_mem[r_rp];
         if (w_push) r_wp   <= r_wp + 1'b1;
         if (w_pop)  r_rp   <= r_rp + 1'b1;
         if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prom_we   <= '0;
         r_prom_addr <= '0;
         r_prom_data <= '0;
         r_dl_d      <= 1'b0;
         r_ovf       <= 1'b0;
         r_pend      <= 1'b0;
      end else begin
         r_prom_we <= w_prom_wr ? w_strb : '0;
         if (w_prom_wr) begin
            r_prom_addr <= bus.ioctl_addr[7:0];
            r_prom_data <= bus.ioctl_dout;
         end
         r_dl_d <= bus.downloading;
         if (w_rise)      r_ovf <= 1'b0;
         else if (w_drop) r_ovf <= 1'b1;
         if (w_done || w_rise) r_pend <= 1'b0;
         else if (w_fall)      r_pend <= 1'b1;
      end
   end

   assign bus.prog_addr = r_prog.addr;
   assign bus.prog_mask = r_prog.mask;
   assign bus.prog_data = r_prog.data;
   assign bus.prog_we   = (r_state == S_REQ);
   assign bus.prom_we   = r_prom_we;
   assign bus.prom_addr = r_prom_addr;
   assign bus.prom_data = r_prom_data;
   assign bus.fifo_full = w_full;
   assign bus.ovf       = r_ovf;
   assign bus.dwn_done  = w_done;
endmodule

// File: tb/tb_jtdd_dwnld_router.sv
// Directed bench for jtdd_dwnld_router: expected SDRAM writes queue in a scoreboard
// and are checked as each write is accepted by sdram_ack.
module tb_jtdd_dwnld_router;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] sb[$];
   int          last_acc, done_cyc, n_done;
   logic        acc;

   logic [25:0] t_a [9] = '{26'h03ABCD, 26'h05ABCD, 26'h050013, 26'h060000, 26'h07A5F3,
                            26'h080000, 26'h0E0000, 26'h112345, 26'h120006};
   logic [21:0] t_x [9] = '{22'h1D5E6, 22'h2D5EA, 22'h28007, 22'h60000, 22'h7A5CF,
                            22'h60000, 22'h80000, 22'hB2354, 22'h180003};
   logic [1:0]  t_m [9] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

   jtdd_dwnld_router_if #(.PW(2)) bus ();

   jtdd_dwnld_router #(.PW(2), .FIFOAW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ent(input logic [21:0] a, input logic [1:0] m, input logic [7:0] d);
      return {a, m, d};
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.prog_we && bus.sdram_ack) begin
         n_cmp++;
         assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL sb_underflow: observed write %h expected none",
                   {bus.prog_addr, bus.prog_mask, bus.prog_data});
         end
         if (sb.size() > 0)
            chk("prog_write", {bus.prog_addr, bus.prog_mask, bus.prog_data}, sb.pop_front());
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [25:0] a, input logic [7:0] d);
      bus.ioctl_addr = a;
      bus.ioctl_dout = d;
      bus.ioctl_wr   = 1'b1;
      step();
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (sb.size() != 0 || bus.prog_we); i++) step();
      chk("drain_empty", 32'(sb.size()), 32'd0);
      chk("drain_idle", bus.prog_we, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.downloading = 1'b0;
      bus.ioctl_addr  = '0;
      bus.ioctl_dout  = '0;
      bus.ioctl_wr    = 1'b0;
      bus.sdram_ack   = 1'b0;
      step(3);
      chk("rst_prog_we", bus.prog_we, 1'b0);
      chk("rst_prog", {bus.prog_addr, bus.prog_mask, bus.prog_data}, 32'd0);
      chk("rst_prom", {bus.prom_we, bus.prom_addr, bus.prom_data}, 32'd0);
      chk("rst_flags", {bus.fifo_full, bus.ovf, bus.dwn_done}, 32'd0);

      rst_n = 1'b1;
      bus.downloading = 1'b1;
      bus.sdram_ack   = 1'b1;
      step(2);

      // first write: prog_we rises two cycles after ioctl_wr
      sb.push_back(ent(22'h00001, 2'b01, 8'hAB));
      wr(26'h3, 8'hAB);
      chk("lat1_we", bus.prog_we, 1'b0);
      step();
      chk("lat2_we", bus.prog_we, 1'b1);
      drain();

      for (int i = 0; i < 9; i++) begin
         sb.push_back(ent(t_x[i], t_m[i], 8'(8'h40 + i)));
         wr(t_a[i], 8'(8'h40 + i));
         drain();
      end

      // PROM strobes bypass the FIFO
      wr(26'h124105, 8'h3C);
      chk("prom1_we", bus.prom_we, 2'b10);
      chk("prom1_addr", bus.prom_addr, 8'h05);
      chk("prom1_data", bus.prom_data, 8'h3C);
      chk("prom1_prog_we", bus.prog_we, 1'b0);
      step();
      chk("prom1_pulse", bus.prom_we, 2'b00);
      wr(26'h124305, 8'h55);
      chk("prom_oob_we", bus.prom_we, 2'b00);
      wr(26'h124000, 8'h11);
      chk("prom0_we", bus.prom_we, 2'b01);
      chk("prom0_addr", bus.prom_addr, 8'h00);
      step(3);
      chk("prom_no_prog", bus.prog_we, 1'b0);
      chk("prom_no_ovf", bus.ovf, 1'b0);

      // burst with ack held low: 1 in REQ, 4 in FIFO, 6th dropped
      bus.sdram_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.ioctl_addr = 26'h10 + 26'(i);
         bus.ioctl_dout = 8'(8'h90 + i);
         bus.ioctl_wr   = 1'b1;
         if (i < 5) sb.push_back(ent(22'h8 + 22'(i / 2), (i % 2 == 1) ? 2'b01 : 2'b10, 8'(8'h90 + i)));
         step();
      end
      bus.ioctl_wr = 1'b0;
      chk("burst_full", bus.fifo_full, 1'b1);
      chk("burst_ovf", bus.ovf, 1'b1);
      chk("burst_we", bus.prog_we, 1'b1);
      step(3);
      chk("burst_hold", {bus.prog_addr, bus.prog_mask, bus.prog_data}, ent(22'h8, 2'b10, 8'h90));
      bus.sdram_ack = 1'b1;
      drain();
      chk("burst_unfull", bus.fifo_full, 1'b0);
      chk("burst_ovf_sticky", bus.ovf, 1'b1);

      // end of download with 3 queued writes, ack every 4th cycle
      bus.sdram_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(ent(22'h10, (i % 2 == 1) ? 2'b01 : 2'b10, 8'(8'hC0 + i)));
         wr(26'h20 + 26'(i % 2), 8'(8'hC0 + i));
      end
      bus.downloading = 1'b0;
      last_acc = -1;
      done_cyc = -1;
      n_done   = 0;
      for (int i = 0; i < 40; i++) begin
         bus.sdram_ack = (i % 4 == 3);
         acc = bus.prog_we && bus.sdram_ack;
         step();
         if (acc) last_acc = i;
         if (bus.dwn_done) begin
            n_done++;
            done_cyc = i;
         end
      end
      chk("done_count", 32'(n_done), 32'd1);
      chk("done_cycle", 32'(done_cyc), 32'd11);
      chk("done_after_ack", 32'(done_cyc), 32'(last_acc));
      chk("done_drained", 32'(sb.size()), 32'd0);

      // writes outside a download are ignored
      bus.sdram_ack = 1'b1;
      wr(26'h40, 8'h77);
      step(4);
      chk("idle_wr_we", bus.prog_we, 1'b0);
      chk("idle_wr_done", bus.dwn_done, 1'b0);

      bus.downloading = 1'b1;
      step();
      chk("ovf_clear_on_rise", bus.ovf, 1'b0);

      // reset in the middle of a stalled transfer
      bus.sdram_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.ioctl_addr = 26'h30 + 26'(i);
         bus.ioctl_dout = 8'(i);
         bus.ioctl_wr   = 1'b1;
         step();
      end
      bus.ioctl_wr = 1'b0;
      chk("pre_rst_we", bus.prog_we, 1'b1);
      chk("pre_rst_ovf", bus.ovf, 1'b1);
      bus.downloading = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we", bus.prog_we, 1'b0);
      chk("rst_mid_flags", {bus.fifo_full, bus.ovf}, 32'd0);
      step(2);
      rst_n = 1'b1;
      bus.sdram_ack = 1'b1;
      n_done = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.dwn_done) n_done++;
      end
      chk("rst_no_done", 32'(n_done), 32'd0);
      chk("rst_no_we", bus.prog_we, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
